// File: rtl/spi_fsm_pkg.sv
// spi_fsm_pkg: frame constants and state encoding shared by the SPI slave controller
package spi_fsm_pkg;

    localparam int SPI_FRAME_BITS = 8;
    localparam int RW_BIT_INDEX   = 0;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        GET_ADDR    = 3'd1,
        LATCH_ADDR  = 3'd2,
        READ_LOAD   = 3'd3,
        READ_SHIFT  = 3'd4,
        WRITE_GET   = 3'd5,
        WRITE_STORE = 3'd6,
        DONE        = 3'd7
    } spiState;

endpackage

// File: rtl/spi_fsm_bit_counter.sv
// bit_counter: counts conditioned SCLK edges up to width and holds there
module bit_counter
    import spi_fsm_pkg::*;
#(
    parameter int width    = SPI_FRAME_BITS,
    parameter int cntWidth = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic inc,
    output logic done
);

    logic [cntWidth-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) count <= '0;
        else if (clear) count <= '0;
        else if (inc && !done) count <= count + 1'b1;
    end

    assign done = count == cntWidth'(width);

endmodule

// File: rtl/spi_fsm.sv
// spi_fsm: per-CS-window transaction controller (address + R/W, then one data byte)
module spi_fsm
    import spi_fsm_pkg::*;
#(
    parameter int width    = SPI_FRAME_BITS,
    parameter int cntWidth = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             csConditioned,
    input  logic             sclkPosEdge,
    input  logic [width-1:0] shiftRegOut,
    output logic             addrWe,
    output logic             srWe,
    output logic             dmWe,
    output logic             misoBufe
);

    spiState state, nextState;
    logic cntClear, cntInc, cntDone;
    logic unusedSr;

    assign unusedSr = ^shiftRegOut;

    bit_counter #(.width(width), .cntWidth(cntWidth)) counter (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (cntClear),
        .inc    (cntInc),
        .done   (cntDone)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= nextState;
    end

    always_comb begin
        nextState = state;
        cntClear  = 1'b0;
        cntInc    = 1'b0;
        case (state)
            IDLE: begin
                cntClear  = 1'b1;
                nextState = GET_ADDR;
            end
            GET_ADDR: begin
                cntInc    = sclkPosEdge;
                nextState = cntDone ? LATCH_ADDR : GET_ADDR;
            end
            LATCH_ADDR: begin
                cntClear  = 1'b1;
                nextState = shiftRegOut[RW_BIT_INDEX] ? READ_LOAD : WRITE_GET;
            end
            READ_LOAD: nextState = READ_SHIFT;
            READ_SHIFT: begin
                cntInc    = sclkPosEdge;
                nextState = cntDone ? DONE : READ_SHIFT;
            end
            WRITE_GET: begin
                cntInc    = sclkPosEdge;
                nextState = cntDone ? WRITE_STORE : WRITE_GET;
            end
            WRITE_STORE: nextState = DONE;
            default: nextState = DONE;
        endcase
        // CS high aborts from anywhere, beating a coincident SCLK edge
        if (csConditioned) begin
            nextState = IDLE;
            cntClear  = 1'b1;
            cntInc    = 1'b0;
        end
    end

    assign addrWe   = state == LATCH_ADDR;
    assign srWe     = state == READ_LOAD;
    assign dmWe     = state == WRITE_STORE;
    assign misoBufe = state == READ_SHIFT;

endmodule

// File: tb/tb_spi_fsm.sv
// tb_spi_fsm: randomized transactions checked against an edge-timing reference model
module tb_spi_fsm;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       csConditioned = 1'b1;
    logic       sclkPosEdge = 1'b0;
    logic [7:0] shiftRegOut = 8'h00;
    logic       addrWe, srWe, dmWe, misoBufe;

    int checkCount = 0;
    int passCount = 0;
    logic [7:0] sr;

    spi_fsm #(.width(8), .cntWidth(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .csConditioned(csConditioned),
        .sclkPosEdge  (sclkPosEdge),
        .shiftRegOut  (shiftRegOut),
        .addrWe       (addrWe),
        .srWe         (srWe),
        .dmWe         (dmWe),
        .misoBufe     (misoBufe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [7:0] outs();
        return {4'b0, addrWe, srWe, dmWe, misoBufe};
    endfunction

    // abortKind: 0 none, 1 CS high two clk after edge number abortArg, 2 CS high on the 16th edge, 3 random cycle
    // stopAt > 0 returns right after the sample following edge number stopAt
    task automatic runTxn(input logic [6:0] addr, input logic rw, input logic [7:0] data,
                          input int abortKind, input int abortArg, input int extraEdges, input int stopAt);
        logic       isEdge[256];
        logic [3:0] expOut[256];
        int         edgeAt[19];
        logic [15:0] word;
        int pos, e, d, a, endc, bitIdx, stopCycle, nEdges;
        word = {addr, rw, data};
        for (int i = 0; i < 256; i++) begin
            isEdge[i] = 1'b0;
            expOut[i] = 4'b0;
        end
        nEdges = 16 + extraEdges;
        pos = 1 + int'($urandom_range(0, 2));
        for (int i = 0; i < nEdges; i++) begin
            edgeAt[i] = pos;
            pos += 4 + int'($urandom_range(0, 2));
        end
        e = edgeAt[7];
        d = edgeAt[15];
        endc = pos + int'($urandom_range(0, 2));
        a = endc;
        if (abortKind == 1) a = edgeAt[abortArg-1] + 2;
        else if (abortKind == 2) a = d;
        else if (abortKind == 3) a = int'($urandom_range(1, endc - 1));
        stopCycle = stopAt > 0 ? edgeAt[stopAt-1] + 1 : -1;
        for (int i = 0; i < nEdges; i++) if (edgeAt[i] <= a) isEdge[edgeAt[i]] = 1'b1;
        // expected outputs as {addrWe, srWe, dmWe, misoBufe}, derived from edge times
        expOut[e+1] = 4'b1000;
        if (rw) begin
            expOut[e+2] = 4'b0100;
            for (int s = e + 3; s <= d; s++) expOut[s] = 4'b0001;
        end else begin
            expOut[d+1] = 4'b0010;
        end
        for (int s = a; s < 256; s++) expOut[s] = 4'b0;
        bitIdx = 0;
        for (int c = 0; c <= a + 1; c++) begin
            csConditioned = c >= a;
            sclkPosEdge   = isEdge[c];
            @(posedge clk);
            #1;
            if (isEdge[c]) begin
                sr = {sr[6:0], bitIdx < 16 ? word[15-bitIdx] : 1'($urandom)};
                bitIdx++;
                shiftRegOut = sr;
            end
            check($sformatf("cyc%0d", c), outs(), {4'b0, expOut[c]});
            if (dmWe) check("dmData", shiftRegOut, data);
            if (c == stopCycle) begin
                sclkPosEdge = 1'b0;
                return;
            end
        end
        sclkPosEdge = 1'b0;
    endtask

    initial begin
        sr = 8'($urandom);
        shiftRegOut = sr;
        repeat (3) @(posedge clk);
        #1;
        check("reset", outs(), 8'h00);
        @(negedge clk);
        reset_n = 1'b1;

        runTxn(7'h15, 1'b1, 8'($urandom), 0, 0, 0, 0);
        runTxn(7'h2A, 1'b0, 8'hC3, 0, 0, 0, 0);
        runTxn(7'($urandom), 1'b0, 8'($urandom), 1, 13, 0, 0);
        runTxn(7'($urandom), 1'b0, 8'($urandom), 0, 0, 0, 0);
        runTxn(7'($urandom), 1'b0, 8'($urandom), 2, 0, 0, 0);
        runTxn(7'($urandom), 1'b0, 8'($urandom), 0, 0, 3, 0);
        runTxn(7'($urandom), 1'b1, 8'($urandom), 0, 0, 3, 0);

        runTxn(7'h15, 1'b1, 8'($urandom), 0, 0, 0, 11);
        check("preRst", outs(), 8'h01);
        #2 reset_n = 1'b0;
        #1 check("asyncRst", outs(), 8'h00);
        @(negedge clk);
        csConditioned = 1'b1;
        reset_n = 1'b1;
        @(posedge clk);
        #1 check("postRst", outs(), 8'h00);
        runTxn(7'($urandom), 1'b1, 8'($urandom), 0, 0, 0, 0);

        repeat (40) begin
            int kind;
            kind = int'($urandom_range(0, 5));
            runTxn(7'($urandom), 1'($urandom), 8'($urandom), kind > 3 ? 0 : kind,
                   int'($urandom_range(1, 16)), int'($urandom_range(0, 3)), 0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
